// File: rtl/apb_timer_mc.sv
// apb_timer_mc: multi-channel APB3 timer with a shared prescaler.
//
// Each of NUM_CH channels has CTRL (EN, MODE, IE), CMP, CNT and W1C STATUS
// (MATCH, OVF) at base n*0x10. PRESCALE lives at 0xF0. Zero-wait-state slave.
//
// Ports:
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE  APB control
//   PADDR, PWDATA          APB byte address, write data
//   PRDATA, PREADY         read data (0 outside read access), always ready
//   PSLVERR                error on unmapped or unaligned access
//   IRQ, IRQ_ANY           per-channel MATCH & IE, and their OR
module apb_timer_mc #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned PRE_W  = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] IRQ,
  output logic              IRQ_ANY
);

  logic [2:0]       ctrl_q [NUM_CH];
  logic [2:0]       ctrl_d [NUM_CH];
  logic [CNT_W-1:0] cmp_q  [NUM_CH];
  logic [CNT_W-1:0] cmp_d  [NUM_CH];
  logic [CNT_W-1:0] cnt_q  [NUM_CH];
  logic [CNT_W-1:0] cnt_d  [NUM_CH];
  logic [1:0]       sts_q  [NUM_CH];
  logic [1:0]       sts_d  [NUM_CH];
  logic [1:0]       hw_set [NUM_CH];
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  logic        access, is_pre, ch_ok, addr_err, wr_en, tick;
  logic [3:0]  ch_idx;
  logic [1:0]  reg_idx;
  logic [31:0] rdata;
  logic        unused_wdata;

  assign access   = PSEL & PENABLE;
  assign ch_idx   = PADDR[7:4];
  assign reg_idx  = PADDR[3:2];
  assign is_pre   = (PADDR == 8'hF0);
  // Channel 15 is never valid (NUM_CH <= 15), so 0xF0 cannot alias a channel.
  assign ch_ok    = ({28'd0, ch_idx} < NUM_CH);
  assign addr_err = (PADDR[1:0] != 2'b00) | ~(is_pre | ch_ok);
  assign wr_en    = access & PWRITE & ~addr_err;
  assign tick     = (pre_cnt_q == pre_q);

  assign PREADY       = 1'b1;
  assign PSLVERR      = PRESETn & access & addr_err;
  assign unused_wdata = ^PWDATA;

  // Prescaler: a PRESCALE write restarts the tick phase.
  always_comb begin
    pre_d     = pre_q;
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    if (wr_en && is_pre) begin
      pre_d     = PWDATA[PRE_W-1:0];
      pre_cnt_d = '0;
    end
  end

  // Channels: hardware update first, then software writes override it.
  always_comb begin
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      ctrl_d[n] = ctrl_q[n];
      cmp_d[n]  = cmp_q[n];
      cnt_d[n]  = cnt_q[n];
      sts_d[n]  = sts_q[n];
      hw_set[n] = 2'b00;
      if (tick && ctrl_q[n][0]) begin
        if (cnt_q[n] == cmp_q[n]) begin
          hw_set[n][0] = 1'b1;
          if (ctrl_q[n][1]) ctrl_d[n][0] = 1'b0;
          else              cnt_d[n]     = '0;
        end else if (cnt_q[n] == {CNT_W{1'b1}}) begin
          hw_set[n][1] = 1'b1;
          cnt_d[n]     = '0;
        end else begin
          cnt_d[n] = cnt_q[n] + CNT_W'(1);
        end
      end
      if (wr_en && !is_pre && (ch_idx == 4'(n))) begin
        unique case (reg_idx)
          2'd0: ctrl_d[n] = PWDATA[2:0];
          2'd1: cmp_d[n]  = PWDATA[CNT_W-1:0];
          2'd2: cnt_d[n]  = PWDATA[CNT_W-1:0];
          2'd3: sts_d[n]  = sts_q[n] & ~PWDATA[1:0];
          default: ;
        endcase
      end
      // Hardware set beats a simultaneous W1C.
      sts_d[n] = sts_d[n] | hw_set[n];
    end
  end

  always_comb begin
    rdata = '0;
    if (is_pre) rdata = 32'(pre_q);
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      if (!is_pre && (ch_idx == 4'(n))) begin
        unique case (reg_idx)
          2'd0: rdata = {29'd0, ctrl_q[n]};
          2'd1: rdata = 32'(cmp_q[n]);
          2'd2: rdata = 32'(cnt_q[n]);
          2'd3: rdata = {30'd0, sts_q[n]};
          default: ;
        endcase
      end
    end
    PRDATA = (PRESETn && access && !PWRITE && !addr_err) ? rdata : '0;
  end

  always_comb begin
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      IRQ[n] = sts_q[n][0] & ctrl_q[n][2];
    end
    IRQ_ANY = |IRQ;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_q    <= '{default: '0};
      cmp_q     <= '{default: '0};
      cnt_q     <= '{default: '0};
      sts_q     <= '{default: '0};
      pre_q     <= '0;
      pre_cnt_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      cmp_q     <= cmp_d;
      cnt_q     <= cnt_d;
      sts_q     <= sts_d;
      pre_q     <= pre_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_timer_mc.sv
// Directed bench for apb_timer_mc (CNT_W=16, NUM_CH=2, PRE_W=8).
// Bus tasks start and end 1 time unit after a rising edge; reads sample
// PRDATA/PSLVERR mid access phase.
module tb_apb_timer_mc;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned NUM_CH = 2;
  localparam int unsigned PRE_W  = 8;

  logic              PCLK    = 1'b0;
  logic              PRESETn = 1'b0;
  logic              PSEL    = 1'b0;
  logic              PENABLE = 1'b0;
  logic              PWRITE  = 1'b0;
  logic [7:0]        PADDR   = 8'h00;
  logic [31:0]       PWDATA  = 32'h0;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [NUM_CH-1:0] IRQ;
  logic              IRQ_ANY;

  int checks   = 0;
  int failures = 0;

  apb_timer_mc #(
    .CNT_W  (CNT_W),
    .NUM_CH (NUM_CH),
    .PRE_W  (PRE_W)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .IRQ     (IRQ),
    .IRQ_ANY (IRQ_ANY)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    #3 d = PRDATA; e = PSLVERR;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [7:0]  regs [9];
    regs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'hF0};

    // Reset and register access
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    check("reset_irq", {PREADY, IRQ_ANY, IRQ}, 4'b1000);
    for (int i = 0; i < 9; i++) begin
      apb_read(regs[i], rd, er);
      check($sformatf("reset_read_%02h", regs[i]), {er, rd}, 33'h0);
    end
    apb_write(8'h04, 32'h5555_1234);
    apb_read(8'h04, rd, er);
    check("cmp0_rw", {er, rd}, {1'b0, 32'h0000_1234});
    apb_write(8'hF0, 32'h0000_0105);
    apb_read(8'hF0, rd, er);
    check("prescale_rw", {er, rd}, {1'b0, 32'h0000_0005});
    apb_read(8'h24, rd, er);
    check("err_ch2", {er, rd}, {1'b1, 32'h0});
    apb_read(8'hF4, rd, er);
    check("err_ch15", {er, rd}, {1'b1, 32'h0});
    apb_write(8'h06, 32'h0000_FFFF);
    apb_read(8'h04, rd, er);
    check("err_write_noeffect", {er, rd}, {1'b0, 32'h0000_1234});

    // Periodic match, W1C and set-beats-clear collision
    apb_write(8'hF0, 32'h0);
    apb_write(8'h04, 32'h4);
    apb_write(8'h00, 32'h5);           // enable commits on edge E0
    repeat (4) @(posedge PCLK); #1;    // E4+1, CNT0=4
    check("per_irq_before", {IRQ_ANY, IRQ}, 3'b000);
    apb_read(8'h08, rd, er);           // sampled after E5 match
    check("per_cnt_wrap", rd, 32'h0);
    check("per_irq_set", {IRQ_ANY, IRQ}, 3'b101);
    apb_write(8'h0C, 32'h1);           // W1C on E8
    check("per_irq_w1c", {IRQ_ANY, IRQ}, 3'b000);
    @(posedge PCLK); #1;
    check("per_irq_gap", {IRQ_ANY, IRQ}, 3'b000);
    @(posedge PCLK); #1;               // E10 match
    check("per_irq_again", {IRQ_ANY, IRQ}, 3'b101);
    repeat (3) @(posedge PCLK); #1;
    apb_write(8'h0C, 32'h1);           // W1C lands on the E15 match edge
    check("coll_irq", {IRQ_ANY, IRQ}, 3'b101);
    apb_read(8'h0C, rd, er);
    check("coll_status", rd, 32'h1);
    apb_write(8'h00, 32'h0);
    apb_write(8'h0C, 32'h3);
    check("per_stopped_irq", {IRQ_ANY, IRQ}, 3'b000);

    // Prescaler and one-shot on channel 1
    apb_write(8'hF0, 32'h3);           // P0; ticks on P4, P8, ...
    apb_write(8'h14, 32'h2);
    apb_write(8'h10, 32'h7);           // P4
    repeat (11) @(posedge PCLK); #1;
    check("os_irq_before", {IRQ_ANY, IRQ}, 3'b000);
    @(posedge PCLK); #1;               // P16 match
    check("os_irq_set", {IRQ_ANY, IRQ}, 3'b110);
    apb_read(8'h10, rd, er);
    check("os_ctrl_en_clr", rd, 32'h6);
    apb_read(8'h18, rd, er);
    check("os_cnt_hold", rd, 32'h2);
    apb_write(8'h1C, 32'h1);
    repeat (100) @(posedge PCLK); #1;
    check("os_irq_quiet", {IRQ_ANY, IRQ}, 3'b000);
    apb_read(8'h1C, rd, er);
    check("os_status_quiet", rd, 32'h0);
    apb_read(8'h18, rd, er);
    check("os_cnt_still", rd, 32'h2);

    // Overflow on channel 0
    apb_write(8'h04, 32'h10);
    apb_write(8'h08, 32'hFFFE);
    apb_write(8'hF0, 32'h0);
    apb_write(8'h00, 32'h1);           // O0
    apb_read(8'h08, rd, er);           // after O1
    check("ovf_cnt_max", rd, 32'hFFFF);
    apb_read(8'h0C, rd, er);           // after O3, OVF set on O2
    check("ovf_status", rd, 32'h2);
    check("ovf_no_irq", {IRQ_ANY, IRQ}, 3'b000);
    repeat (13) @(posedge PCLK); #1;
    apb_read(8'h08, rd, er);           // after O18
    check("ovf_cnt_at_cmp", rd, 32'h10);
    apb_read(8'h08, rd, er);           // after O20, match on O19
    check("ovf_match_wrap", rd, 32'h1);
    apb_read(8'h0C, rd, er);
    check("ovf_match_status", rd, 32'h3);
    check("ovf_match_no_irq", {IRQ_ANY, IRQ}, 3'b000);

    // CNT write on a tick edge: the write wins, then one further tick
    apb_write(8'h08, 32'hABCD_0100);
    apb_read(8'h08, rd, er);
    check("cnt_write_tick", rd, 32'h0101);

    // Asynchronous reset mid-count
    apb_write(8'h00, 32'h5);
    check("rst_pre_irq", {IRQ_ANY, IRQ}, 3'b101);
    @(posedge PCLK); #3 PRESETn = 1'b0;
    #1;
    check("rst_async", {PSLVERR, PRDATA, IRQ_ANY, IRQ}, 36'h0);
    repeat (2) @(posedge PCLK);
    #3 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    repeat (50) @(posedge PCLK); #1;
    check("rst_irq_quiet", {IRQ_ANY, IRQ}, 3'b000);
    apb_read(8'h08, rd, er);
    check("rst_cnt0", rd, 32'h0);
    apb_read(8'h00, rd, er);
    check("rst_ctrl0", rd, 32'h0);
    apb_read(8'hF0, rd, er);
    check("rst_prescale", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_timer_mc.md
Name: apb_timer_mc

Overview:
- Multi-channel, parametrised APB3 timer. Successor to the single-channel 8-bit APB timer.
- Adds three things the earlier block lacks: configurable counter width, N independent compare channels, and a shared prescaler.
- Each channel supports periodic and one-shot modes, with sticky status and a maskable interrupt.
- Sits on the peripheral APB bus as a zero-wait-state slave.

Parameters:
- CNT_W, 16, counter/compare width in bits (1..32).
- NUM_CH, 2, number of timer channels (1..15).
- PRE_W, 8, prescaler width in bits (1..32).

Ports:
- PCLK  in  1  bus and timer clock.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  APB slave select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  8  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error.
- IRQ  out  NUM_CH  per-channel interrupt, level-high.
- IRQ_ANY  out  1  OR of IRQ.

Behaviour:
- Clock and reset: one clock, PCLK. Reset PRESETn is asynchronous and active-low. Reset clears all registers, counters and the prescaler to 0. Outputs under reset: PRDATA=0, PSLVERR=0, IRQ=0, IRQ_ANY=0. PREADY is tied to 1. Reset asserted mid-count aborts all activity immediately, with no pending events after release.
- APB timing: setup phase is PSEL=1, PENABLE=0. Access phase is PSEL=1, PENABLE=1. No wait states.
  - Writes commit on the PCLK rising edge ending the access phase.
  - PRDATA is combinational from register state during a read access phase, and 0 otherwise.
  - PSLVERR is combinational, asserted only in the access phase.
- Address map: channel n base = n*0x10, for n < NUM_CH.
  - +0x0 CTRL, RW: bit0 EN, bit1 MODE (0 periodic, 1 one-shot), bit2 IE. Other bits read 0.
  - +0x4 CMP, RW, CNT_W bits, zero-extended on read.
  - +0x8 CNT, RW. A write loads the counter directly.
  - +0xC STATUS, W1C: bit0 MATCH, bit1 OVF.
  - 0xF0 PRESCALE, RW, PRE_W bits.
- Error conditions: PSLVERR=1 for any address not listed above, including channel index >= NUM_CH and unaligned addresses (PADDR[1:0] != 0). An erroring write changes no state; an erroring read returns 0.
- Prescaler: free-running pre_cnt.
  - When pre_cnt == PRESCALE: tick=1 and pre_cnt returns to 0; otherwise pre_cnt increments.
  - PRESCALE=0 gives a tick every cycle. Tick period = PRESCALE+1 cycles.
  - A write to PRESCALE also clears pre_cnt.
- Channel counting happens on a tick with EN=1 (EN=0 holds CNT):
  - If CNT == CMP: match event. STATUS.MATCH is set.
    - Periodic: CNT becomes 0.
    - One-shot: CNT holds and EN clears.
  - Else if CNT == 2^CNT_W-1: CNT wraps to 0 and STATUS.OVF is set. This is reachable only when software has loaded CNT > CMP.
  - Else CNT increments.
  - Match period in periodic mode = (CMP+1) ticks.
- Interrupts:
  - IRQ[n] = STATUS[n].MATCH & CTRL[n].IE, registered-state combinational.
  - OVF does not drive IRQ.
- Simultaneous events:
  - A hardware set of MATCH/OVF on the same edge as a W1C of that bit: set wins.
  - A CNT write on the same edge as a tick: the write wins and no count occurs that cycle.
  - A CTRL write clearing EN on the same edge as a match: EN=0, MATCH still set.
  - A one-shot hardware EN clear on the same edge as a software CTRL write: the written value wins.
  - A CMP write takes effect for the comparison on the next tick.
- Width rules: writes to CMP, CNT and PRESCALE truncate PWDATA to the field width. Reads zero-extend.

Test Plan:
- Register access and reset values: reset, then read every register → all return 0.
  - Write CMP0=0x1234, PRESCALE=0x05 and read back → exact values.
  - Read 0x24 with NUM_CH=2 → PSLVERR=1, PRDATA=0.
- Periodic match: PRESCALE=0, CMP0=4, CTRL0=0x5 →
  - IRQ[0] rises 5 cycles after enable and CNT0 returns to 0.
  - W1C STATUS0=0x1 drops IRQ[0].
  - IRQ[0] re-asserts 5 cycles after the previous match.
- Prescaler and one-shot: PRESCALE=3, CMP1=2, CTRL1=0x7 →
  - MATCH sets after 12 cycles, CTRL1 reads 0x6, and CNT1 holds at 2.
  - No further matches over 100 cycles.
- Overflow (CNT_W=16): CMP0=0x10, write CNT0=0xFFFE, EN=1, PRESCALE=0 →
  - OVF sets after 2 ticks, CNT0=0, IRQ[0] stays 0.
  - MATCH sets 17 ticks later.
- Collision: arrange W1C of MATCH on the exact edge of a new match → MATCH reads 1.
  - Write CNT on a tick edge → CNT equals the written value.
- Mid-operation reset: pull PRESETn low asynchronously between clock edges while counting →
  - All outputs go to 0 immediately.
  - After release, no IRQ occurs and CNT stays 0.
